// File: rtl/rr_req_arbiter_n.sv
// N-master round-robin request arbiter for one slave port: grants one waiting master,
// registers its command/address/write data, and holds it until the slave acknowledges.
module rr_req_arbiter_n #(
    parameter int          N_MST     = 4,
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          SW        = 1,
    parameter logic [1:0]  WAIT_CODE = 2'd1,
    localparam int         GW        = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW-1:0]         s_no,
    input  logic [2*N_MST-1:0]    req_stat,
    input  logic [SW*N_MST-1:0]   sfor,
    input  logic [N_MST-1:0]      cmd,
    input  logic [AW*N_MST-1:0]   addr,
    input  logic [DW*N_MST-1:0]   wdata,
    input  logic                  s_ack,
    output logic [N_MST-1:0]      perm,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic [AW-1:0]         addr_to,
    output logic                  cmd_to,
    output logic [DW-1:0]         wdata_to
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_grant;

    logic [GW-1:0]      r_last;
    logic [N_MST-1:0]   r_perm;
    logic [GW-1:0]      r_grant_id;
    logic [AW-1:0]      r_addr_to;
    logic               r_cmd_to;
    logic [DW-1:0]      r_wdata_to;

    logic [N_MST-1:0]   w_elig;
    logic               w_found;
    logic [GW-1:0]      w_win;
    logic [GW-1:0]      w_idx;
    logic [N_MST-1:0]   w_onehot;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_MST; i++) begin
            w_elig[i] = (sfor[i*SW +: SW] == s_no) && (req_stat[2*i +: 2] == WAIT_CODE);
        end
    end

    // Scan starts just after the previous winner, so only the winner drops to lowest
    // priority and every loser keeps its relative order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_MST; k++) begin
            w_idx = GW'((int'(r_last) + k) % N_MST);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_onehot = {{(N_MST-1){1'b0}}, 1'b1} << w_win;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_BUSY;
                    w_grant      = 1'b1;
                end
            end
            ST_BUSY: begin
                if (s_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last     <= GW'(N_MST - 1);
            r_perm     <= '0;
            r_grant_id <= '0;
            r_addr_to  <= '0;
            r_cmd_to   <= 1'b0;
            r_wdata_to <= '0;
        end else if (w_grant) begin
            r_last     <= w_win;
            r_perm     <= w_onehot;
            r_grant_id <= w_win;
            r_addr_to  <= addr[int'(w_win)*AW +: AW];
            r_cmd_to   <= cmd[w_win];
            r_wdata_to <= wdata[int'(w_win)*DW +: DW];
        end else begin
            r_perm     <= '0;
        end
    end

    assign perm     = r_perm;
    assign busy     = (r_state == ST_BUSY);
    assign grant_id = r_grant_id;
    assign addr_to  = r_addr_to;
    assign cmd_to   = r_cmd_to;
    assign wdata_to = r_wdata_to;

endmodule

// File: tb/tb_rr_req_arbiter_n.sv
// Directed bench for rr_req_arbiter_n: table of per-cycle vectors plus hand-written
// sequences for reset, single-master grant, request filtering and mid-transaction reset.
module tb_rr_req_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [SW-1:0]     s_no;
    logic [2*N-1:0]    req_stat;
    logic [SW*N-1:0]   sfor;
    logic [N-1:0]      cmd;
    logic [AW*N-1:0]   addr;
    logic [DW*N-1:0]   wdata;
    logic              s_ack;
    logic [N-1:0]      perm;
    logic              busy;
    logic [1:0]        grant_id;
    logic [AW-1:0]     addr_to;
    logic              cmd_to;
    logic [DW-1:0]     wdata_to;

    int n_checks = 0;
    int n_errors = 0;

    rr_req_arbiter_n #(
        .N_MST(N), .AW(AW), .DW(DW), .SW(SW), .WAIT_CODE(2'd1)
    ) dut (
        .clk(clk), .reset(reset), .s_no(s_no), .req_stat(req_stat), .sfor(sfor),
        .cmd(cmd), .addr(addr), .wdata(wdata), .s_ack(s_ack), .perm(perm),
        .busy(busy), .grant_id(grant_id), .addr_to(addr_to), .cmd_to(cmd_to),
        .wdata_to(wdata_to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [3:0] sf;
        logic       ack;
        logic [3:0] exp_perm;
        logic       exp_busy;
        logic [1:0] exp_gid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] wdata_of(input int i);
        return 32'hA0A0_0000 + 32'(i);
    endfunction

    task automatic load_default_data();
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = addr_of(i);
            wdata[i*DW +: DW] = wdata_of(i);
        end
    endtask

    task automatic add(input logic [7:0] req, input logic [3:0] sf, input logic ack,
                       input logic [3:0] p, input logic b, input logic [1:0] g);
        vec_t v;
        v.req = req; v.sf = sf; v.ack = ack;
        v.exp_perm = p; v.exp_busy = b; v.exp_gid = g;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " perm"},     64'(perm),     64'h0);
        check({tag, " busy"},     64'(busy),     64'h0);
        check({tag, " grant_id"}, 64'(grant_id), 64'h0);
        check({tag, " addr_to"},  64'(addr_to),  64'h0);
        check({tag, " cmd_to"},   64'(cmd_to),   64'h0);
        check({tag, " wdata_to"}, 64'(wdata_to), 64'h0);
    endtask

    initial begin
        logic exp_cmd;
        exp_cmd  = 1'b0;
        reset    = 1'b0;
        s_no     = 1'b1;
        req_stat = '0;
        sfor     = '1;
        cmd      = '0;
        s_ack    = 1'b0;
        load_default_data();

        // Reset, then idle with no requests.
        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_all_zero($sformatf("idle%0d", c));
        end

        // Single master 2 with a write.
        addr[2*AW +: AW]  = 32'h1000_0040;
        wdata[2*DW +: DW] = 32'hDEAD_BEEF;
        cmd               = 4'b0100;
        req_stat          = 8'h10;
        tick();
        check("single perm",     64'(perm),     64'h4);
        check("single busy",     64'(busy),     64'h1);
        check("single grant_id", 64'(grant_id), 64'h2);
        check("single addr_to",  64'(addr_to),  64'h1000_0040);
        check("single cmd_to",   64'(cmd_to),   64'h1);
        check("single wdata_to", 64'(wdata_to), 64'hDEAD_BEEF);
        for (int c = 1; c <= 2; c++) begin
            tick();
            check($sformatf("single hold%0d perm", c), 64'(perm), 64'h0);
            check($sformatf("single hold%0d busy", c), 64'(busy), 64'h1);
        end
        s_ack = 1'b1;
        tick();
        check("single ack busy", 64'(busy), 64'h0);
        s_ack    = 1'b0;
        req_stat = '0;
        load_default_data();

        // Fresh reset so the table starts with master 0 first.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cmd   = 4'b1010;

        // Rotation 0,1,2,3,0,1 with acks one cycle after each grant.
        add(8'h55, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add(8'h55, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd1);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1);
        add(8'h55, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2);
        add(8'h55, 4'hF, 1'b0, 4'b1000, 1'b1, 2'd3);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3);
        add(8'h55, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add(8'h55, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd1);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1);
        // Wrap-around: grant 3, then only 3 and 0 wait -> 0, then 3.
        add(8'h40, 4'hF, 1'b0, 4'b1000, 1'b1, 2'd3);
        add(8'h41, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3);
        add(8'h41, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0);
        add(8'h41, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add(8'h41, 4'hF, 1'b0, 4'b1000, 1'b1, 2'd3);
        add(8'h01, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3);
        // Master 1 addressed elsewhere, master 0 not in WAIT.
        add(8'h06, 4'hD, 1'b0, 4'b0000, 1'b0, 2'd3);
        add(8'h06, 4'hD, 1'b0, 4'b0000, 1'b0, 2'd3);
        // s_ack in IDLE does nothing, and does not block a grant.
        add(8'h00, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3);
        add(8'h10, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2);
        // Requests ignored while BUSY.
        add(8'h55, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2);
        add(8'h55, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd2);
        add(8'h55, 4'hF, 1'b0, 4'b1000, 1'b1, 2'd3);
        add(8'h55, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            req_stat = vecs[i].req;
            sfor     = vecs[i].sf;
            s_ack    = vecs[i].ack;
            tick();
            if (vecs[i].exp_perm != 4'b0000) exp_cmd = cmd[vecs[i].exp_gid];
            check($sformatf("v%0d perm", i),     64'(perm),     64'(vecs[i].exp_perm));
            check($sformatf("v%0d busy", i),     64'(busy),     64'(vecs[i].exp_busy));
            check($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vecs[i].exp_gid));
            check($sformatf("v%0d addr_to", i),  64'(addr_to),  64'(addr_of(int'(vecs[i].exp_gid))));
            check($sformatf("v%0d wdata_to", i), 64'(wdata_to), 64'(wdata_of(int'(vecs[i].exp_gid))));
            check($sformatf("v%0d cmd_to", i),   64'(cmd_to),   64'(exp_cmd));
        end

        // Filtering held for 10 cycles.
        req_stat = 8'h06;
        sfor     = 4'hD;
        s_ack    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("filter%0d perm", c), 64'(perm), 64'h0);
            check($sformatf("filter%0d busy", c), 64'(busy), 64'h0);
        end

        // Hold while BUSY, then reset mid-transaction.
        sfor     = 4'hF;
        req_stat = 8'h55;
        tick();
        check("hold grant perm", 64'(perm), 64'h1);
        addr[0 +: AW] = 32'hFFFF_0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold%0d addr_to", c), 64'(addr_to), 64'h1000_0000);
            check($sformatf("hold%0d perm", c),    64'(perm),    64'h0);
            check($sformatf("hold%0d busy", c),    64'(busy),    64'h1);
        end
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async reset");
        load_default_data();
        tick();
        reset = 1'b1;
        tick();
        check("post-reset perm",     64'(perm),     64'h1);
        check("post-reset grant_id", 64'(grant_id), 64'h0);
        check("post-reset addr_to",  64'(addr_to),  64'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
